// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
//   pe_state_e : drain controller states
//   sat_max/sat_min : saturation bounds for a given accumulator width/signedness
//                     (returned zero-extended in 64 bits; callers slice to ACC_W)
//   cnt_w      : drain counter width for a given chain position (minimum 1)
package pe_pkg;

  typedef enum logic {ST_ACC, ST_DRAIN} pe_state_e;

  function automatic logic [63:0] sat_max(int acc_w, bit sgn);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < acc_w - (sgn ? 1 : 0)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] sat_min(int acc_w, bit sgn);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (sgn && (i == acc_w - 1)) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int cnt_w(int chain_pos);
    return (chain_pos < 1) ? 1 : $clog2(chain_pos + 1);
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational ACC_W adder with optional saturation.
//   a_i, b_i : addends (two's complement when SIGNED, else unsigned)
//   sum_o    : clamped (SAT_EN) or wrapped sum
//   ovf_o    : true sum not representable in ACC_W bits
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int SIGNED = 1,
  parameter int SAT_EN = 1
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam logic [63:0] MAX64 = sat_max(ACC_W, SIGNED != 0);
  localparam logic [63:0] MIN64 = sat_min(ACC_W, SIGNED != 0);
  localparam logic [ACC_W-1:0] MAXV = MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MINV = MIN64[ACC_W-1:0];

  logic [ACC_W:0] raw;
  assign raw = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    sum_o = raw[ACC_W-1:0];
    // Signed overflow: like-signed addends producing an opposite-signed result.
    if (SIGNED != 0) ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
    else             ovf_o = raw[ACC_W];
    // On signed overflow both addends share a sign, so a_i's sign picks the bound.
    if (ovf_o && (SAT_EN != 0))
      sum_o = ((SIGNED != 0) && a_i[ACC_W-1]) ? MINV : MAXV;
  end

endmodule

// File: rtl/pe_mac_stream.sv
// Output-stationary systolic PE with registered multiply, saturating
// accumulate, sticky overflow and a column result drain chain.
//   a_in/a_vin, b_in/b_vin : operands in; forwarded one cycle later on a_out/b_out
//   clear                  : zero accumulator and overflow
//   drain                  : snapshot tile result onto c_out, start pass-through
//   c_in/c_vin             : upstream results passed through while draining
//   c_out/c_vout           : result chain output
//   ovf                    : sticky overflow for the tile being accumulated
//   busy                   : passing upstream results through
module pe_mac_stream
  import pe_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int SIGNED    = 1,
  parameter int SAT_EN    = 1,
  parameter int CHAIN_POS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vin,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vin,
  input  logic              clear,
  input  logic              drain,
  input  logic [ACC_W-1:0]  c_in,
  input  logic              c_vin,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vout,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vout,
  output logic [ACC_W-1:0]  c_out,
  output logic              c_vout,
  output logic              ovf,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = cnt_w(CHAIN_POS);

  pe_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic              av_q, bv_q;
  logic [PW-1:0]     prod_q, prod_d;
  logic              pv_q, pv_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  c_q, c_d;
  logic              cv_q, cv_d;

  logic [PW-1:0]     mul;
  logic [ACC_W-1:0]  prod_ext, addend, sum;
  logic              add_ovf, snap;

  generate
    if (SIGNED != 0) begin : g_sgn
      assign mul      = PW'($signed(a_in)) * PW'($signed(b_in));
      assign prod_ext = ACC_W'($signed(prod_q));
    end else begin : g_uns
      assign mul      = PW'(a_in) * PW'(b_in);
      assign prod_ext = ACC_W'(prod_q);
    end
  endgenerate

  // With no product pending the adder sees +0, so sum is simply acc_q.
  assign addend = pv_q ? prod_ext : '0;

  pe_sat_add #(.ACC_W(ACC_W), .SIGNED(SIGNED), .SAT_EN(SAT_EN)) u_add (
    .a_i   (acc_q),
    .b_i   (addend),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  assign snap = (state_q == ST_ACC) && drain;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cv_d    = 1'b0;
    pv_d    = a_vin & b_vin;
    prod_d  = (a_vin & b_vin) ? mul : prod_q;
    acc_d   = sum;
    ovf_d   = ovf_q | (pv_q & add_ovf);
    // Snapshot takes the accumulator-next value (pending product included,
    // even alongside clear); the next tile starts from zero.
    if (clear || snap) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    case (state_q)
      ST_ACC: begin
        if (drain) begin
          c_d   = sum;
          cv_d  = 1'b1;
          cnt_d = CW'(CHAIN_POS);
          if (CHAIN_POS > 0) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        c_d  = c_in;
        cv_d = c_vin;
        if (c_vin) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      a_q     <= '0;
      av_q    <= 1'b0;
      b_q     <= '0;
      bv_q    <= 1'b0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      c_q     <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_in;
      av_q    <= a_vin;
      b_q     <= b_in;
      bv_q    <= b_vin;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      c_q     <= c_d;
      cv_q    <= cv_d;
    end
  end

  assign a_out  = a_q;
  assign a_vout = av_q;
  assign b_out  = b_q;
  assign b_vout = bv_q;
  assign c_out  = c_q;
  assign c_vout = cv_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pe_mac_stream.sv
// Scoreboard bench: five PE configurations side by side.
//   0: ACC_W=20 signed sat, top of column
//   1: ACC_W=16 signed sat      2: ACC_W=16 signed wrap
//   3: ACC_W=16 unsigned sat    4: ACC_W=20 signed sat, CHAIN_POS=2
module tb_pe_mac_stream;

  localparam int N = 5;
  localparam int AW [N] = '{20, 16, 16, 16, 20};
  localparam int SG [N] = '{1, 1, 1, 0, 1};
  localparam int ST [N] = '{1, 1, 0, 1, 1};
  localparam int CP [N] = '{0, 0, 0, 0, 2};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][7:0]  a_in, b_in, a_out, b_out;
  logic [N-1:0]       a_vin, b_vin, clear, drain, c_vin;
  logic [N-1:0][23:0] c_in;
  logic [N-1:0]       a_vout, b_vout, c_vout, ovf, busy;
  logic [N-1:0][31:0] co;

  int checks = 0;
  int errors = 0;
  int expq [N][$];

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      logic [AW[g]-1:0] c_o;
      pe_mac_stream #(.DATA_W(8), .ACC_W(AW[g]), .SIGNED(SG[g]), .SAT_EN(ST[g]),
                      .CHAIN_POS(CP[g])) u_dut (
        .clk(clk), .reset(reset),
        .a_in(a_in[g]), .a_vin(a_vin[g]), .b_in(b_in[g]), .b_vin(b_vin[g]),
        .clear(clear[g]), .drain(drain[g]),
        .c_in(c_in[g][AW[g]-1:0]), .c_vin(c_vin[g]),
        .a_out(a_out[g]), .a_vout(a_vout[g]), .b_out(b_out[g]), .b_vout(b_vout[g]),
        .c_out(c_o), .c_vout(c_vout[g]), .ovf(ovf[g]), .busy(busy[g])
      );
      assign co[g] = (SG[g] != 0) ? 32'($signed(c_o)) : 32'(c_o);
    end
  endgenerate

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pair(input int k, input int a, input int b);
    a_in[k] = 8'(a); b_in[k] = 8'(b); a_vin[k] = 1'b1; b_vin[k] = 1'b1;
  endtask

  task automatic idle(input int k);
    a_vin[k] = 1'b0; b_vin[k] = 1'b0; drain[k] = 1'b0; clear[k] = 1'b0; c_vin[k] = 1'b0;
  endtask

  initial begin
    a_in = '0; b_in = '0; a_vin = '0; b_vin = '0; clear = '0; drain = '0;
    c_in = '0; c_vin = '0;

    // Monitor: every valid result must match the oldest expected entry.
    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
          if (c_vout[k]) begin
            if (expq[k].size() == 0) begin
              chk($sformatf("c_out%0d_unexpected_valid", k), int'(co[k]), -999999);
            end else begin
              chk($sformatf("c_out%0d", k), int'(co[k]), expq[k].pop_front());
            end
          end
        end
      end
    join_none

    // Reset state
    step(2);
    for (int k = 0; k < N; k++) begin
      chk("rst_cvout", int'(c_vout[k]), 0);
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_ovf", int'(ovf[k]), 0);
    end
    chk("rst_cout0", int'(co[0]), 0);
    reset = 1'b0;

    // Forwarding: one-cycle delay, data forwarded even without valid
    a_in[0] = 8'h5A; b_in[0] = 8'hC3; b_vin[0] = 1'b1;
    #2 chk("fwd_pre_aout", int'(a_out[0]), 0);
    step();
    chk("fwd_aout", int'(a_out[0]), 'h5A);
    chk("fwd_bout", int'(b_out[0]), 'hC3);
    chk("fwd_avout", int'(a_vout[0]), 0);
    chk("fwd_bvout", int'(b_vout[0]), 1);
    a_in[0] = 8'h11;
    step();
    chk("fwd_aout2", int'(a_out[0]), 'h11);
    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1 chk("arst_aout", int'(a_out[0]), 0);
    chk("arst_bvout", int'(b_vout[0]), 0);
    idle(0); a_in[0] = '0; b_in[0] = '0;
    #1 reset = 1'b0;
    step();

    // Basic MAC: 12 - 10 + 49 = 51, then an empty tile
    pair(0, 3, 4); step();
    pair(0, -2, 5); step();
    pair(0, 7, 7); step();
    idle(0); drain[0] = 1'b1; expq[0].push_back(51);
    chk("mac_ovf", int'(ovf[0]), 0);
    step(); drain[0] = 1'b0; step(3);
    drain[0] = 1'b1; expq[0].push_back(0);
    step(); drain[0] = 1'b0; step(2);

    // Saturation / wrap / unsigned on 16-bit accumulators
    for (int p = 0; p < 3; p++) begin
      pair(1, -128, -128); pair(2, -128, -128);
      if (p < 2) pair(3, 255, 255); else idle(3);
      step();
    end
    for (int k = 1; k <= 3; k++) begin
      idle(k); drain[k] = 1'b1;
      chk($sformatf("sat_ovf%0d", k), int'(ovf[k]), 1);
    end
    expq[1].push_back(32767); expq[2].push_back(-16384); expq[3].push_back(65535);
    step();
    for (int k = 1; k <= 3; k++) idle(k);
    chk("sat_ovf_cleared", int'(ovf[1]), 0);
    step(2);

    // clear alone drops acc and ovf
    pair(1, -128, -128); step(2);
    idle(1); step();
    chk("clr_ovf_pre", int'(ovf[1]), 1);
    clear[1] = 1'b1; step();
    clear[1] = 1'b0;
    chk("clr_ovf", int'(ovf[1]), 0);
    drain[1] = 1'b1; expq[1].push_back(0);
    step(); idle(1); step(2);

    // drain with a pair in the same cycle: pair belongs to the next tile
    pair(0, 2, 2); step();
    idle(0); step();
    pair(0, 1, 1); drain[0] = 1'b1; expq[0].push_back(4);
    step(); idle(0); step(2);
    drain[0] = 1'b1; expq[0].push_back(1);
    step(); idle(0); step();

    // clear + drain together: pending product included in the snapshot
    pair(0, 3, 3); step();
    idle(0); drain[0] = 1'b1; clear[0] = 1'b1; expq[0].push_back(9);
    step(); idle(0); step();
    drain[0] = 1'b1; expq[0].push_back(0);
    step(); idle(0); step(2);

    // Chain drain with overlap on PE 4
    pair(4, 3, 3); step();
    idle(4); step();
    drain[4] = 1'b1; expq[4].push_back(9);
    step();
    // in DRAIN: this drain pulse must be ignored
    c_in[4] = 24'd10; c_vin[4] = 1'b1; pair(4, 2, 3); expq[4].push_back(10);
    chk("chain_busy_a", int'(busy[4]), 1);
    step();
    drain[4] = 1'b0; c_vin[4] = 1'b0; c_in[4] = 24'd999; pair(4, 1, 1);
    step();
    idle(4); c_in[4] = 24'd20; c_vin[4] = 1'b1; expq[4].push_back(20);
    chk("chain_busy_b", int'(busy[4]), 1);
    step();
    c_vin[4] = 1'b0;
    chk("chain_busy_done", int'(busy[4]), 0);
    step();
    drain[4] = 1'b1; expq[4].push_back(7);
    step();
    drain[4] = 1'b0;
    chk("redrain_busy", int'(busy[4]), 1);
    c_in[4] = 24'd33; c_vin[4] = 1'b1;
    step();
    c_vin[4] = 1'b0;
    chk("pre_rst_cvout", int'(c_vout[4]), 1);
    chk("pre_rst_cout", int'(co[4]), 33);
    chk("pre_rst_busy", int'(busy[4]), 1);
    // Reset mid-DRAIN aborts immediately
    #2 reset = 1'b1;
    #1 chk("rst_drain_busy", int'(busy[4]), 0);
    chk("rst_drain_cvout", int'(c_vout[4]), 0);
    #1 reset = 1'b0;
    step(2);

    for (int k = 0; k < N; k++)
      chk($sformatf("leftover_expected%0d", k), expq[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
